cv_mem_arbiter: RTL and testbench

- Shares one synchronous external memory port (SDRAM/BRAM front end holding cartridge, expansion ROM/RAM and ADAM RAM) between two requesters: the Z80 and a ROM/cartridge download stream.
- Z80 requests come from the address decoder's chip-enable outputs. The arbiter stretches the Z80 cycle via WAIT until its data is ready.
- Downloads use a valid/ready handshake and are write-only.
- Sits between the address decoder / Z80 and the memory controller in the core top level.

---
 rtl/cv_mem_arbiter_if.sv | 52 +++++
 rtl/cv_mem_arbiter.sv | 119 +++++++++++
 tb/tb_cv_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cv_mem_arbiter_if.sv
// Signal bundle between the Z80 address decoder, the download stream, the
// memory controller and cv_mem_arbiter. The arbiter uses the slave modport.
interface cv_mem_arbiter_if #(
  parameter int ADDR_W = 22
);
  // Z80 side: cpu_req_i is a level held for the whole Z80 access.
  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [7:0]        cpu_d_i;
  logic [7:0]        cpu_d_o;
  logic              cpu_wait_n_o;

  // Download side: valid/ready. The source raises dl_valid_i with address and
  // data and holds all three stable until it sees dl_ready_o high for one
  // cycle; that cycle is the transfer. The arbiter never drops a beat once
  // ready is pulsed, and ready is never pulsed without valid.
  logic              dl_valid_i;
  logic [ADDR_W-1:0] dl_addr_i;
  logic [7:0]        dl_d_i;
  logic              dl_ready_o;

  // Memory side: mem_ce_o is a one-cycle strobe, read data returns later.
  logic              mem_ce_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_d_o;
  logic [7:0]        mem_q_i;

  logic              busy_o;
  logic [1:0]        state_dbg;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_d_i,
    output cpu_d_o, cpu_wait_n_o,
    input  dl_valid_i, dl_addr_i, dl_d_i,
    output dl_ready_o,
    output mem_ce_o, mem_we_o, mem_addr_o, mem_d_o,
    input  mem_q_i,
    output busy_o, state_dbg
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_d_i,
    input  cpu_d_o, cpu_wait_n_o,
    output dl_valid_i, dl_addr_i, dl_d_i,
    input  dl_ready_o,
    input  mem_ce_o, mem_we_o, mem_addr_o, mem_d_o,
    output mem_q_i,
    input  busy_o, state_dbg
  );
endinterface

// File: rtl/cv_mem_arbiter.sv
// Shares one synchronous memory port between Z80 accesses (stretched via WAIT)
// and a write-only download stream, with round-robin arbitration on collisions.
module cv_mem_arbiter #(
  parameter int ADDR_W = 22,
  parameter int RD_LAT = 2
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  cv_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DL_ACC  = 2'd2,
    RD_WAIT = 2'd3
  } state_t;

  localparam logic       GRANT_DL  = 1'b0;
  localparam logic       GRANT_CPU = 1'b1;
  localparam logic [2:0] LAT_INIT  = 3'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic              cpu_done_q;
  logic              last_grant_q;
  logic [2:0]        lat_cnt_q;
  logic              mem_ce_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_d_q;
  logic [7:0]        cpu_d_q;
  logic              dl_ready_q;

  logic cpu_pending;
  logic grant_cpu, grant_dl;
  logic rd_capture, cpu_complete;

  assign cpu_pending  = bus.cpu_req_i & ~cpu_done_q;
  assign rd_capture   = (state_q == RD_WAIT) && (lat_cnt_q == 3'd0);
  assign cpu_complete = ((state_q == CPU_ACC) && mem_we_q) || rd_capture;

  always_comb begin
    grant_cpu = 1'b0;
    grant_dl  = 1'b0;
    state_d   = state_q;
    case (state_q)
      IDLE: begin
        if (cpu_pending && bus.dl_valid_i) begin
          if (last_grant_q == GRANT_CPU) grant_dl  = 1'b1;
          else                           grant_cpu = 1'b1;
        end else if (cpu_pending) begin
          grant_cpu = 1'b1;
        end else if (bus.dl_valid_i) begin
          grant_dl = 1'b1;
        end
        if (grant_cpu)     state_d = CPU_ACC;
        else if (grant_dl) state_d = DL_ACC;
      end
      CPU_ACC: state_d = mem_we_q ? IDLE : RD_WAIT;
      DL_ACC:  state_d = IDLE;
      RD_WAIT: if (lat_cnt_q == 3'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe and bus values are loaded on the grant so they appear, registered,
  // exactly in the issue cycle and then hold.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      cpu_done_q   <= 1'b0;
      last_grant_q <= GRANT_DL;
      lat_cnt_q    <= 3'd0;
      mem_ce_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_d_q      <= 8'h00;
      cpu_d_q      <= 8'hFF;
      dl_ready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_ce_q   <= grant_cpu | grant_dl;
      dl_ready_q <= grant_dl;

      if (grant_cpu) begin
        mem_we_q   <= bus.cpu_we_i;
        mem_addr_q <= bus.cpu_addr_i;
        mem_d_q    <= bus.cpu_d_i;
      end else if (grant_dl) begin
        mem_we_q   <= 1'b1;
        mem_addr_q <= bus.dl_addr_i;
        mem_d_q    <= bus.dl_d_i;
      end

      if (state_q == CPU_ACC)     last_grant_q <= GRANT_CPU;
      else if (state_q == DL_ACC) last_grant_q <= GRANT_DL;

      if ((state_q == CPU_ACC) && !mem_we_q)             lat_cnt_q <= LAT_INIT;
      else if ((state_q == RD_WAIT) && (lat_cnt_q != 0)) lat_cnt_q <= lat_cnt_q - 3'd1;

      if (rd_capture) cpu_d_q <= bus.mem_q_i;

      // A dropped request never leaves cpu_done set, so the next request
      // always gets its own access.
      if (!bus.cpu_req_i)    cpu_done_q <= 1'b0;
      else if (cpu_complete) cpu_done_q <= 1'b1;
    end
  end

  assign bus.cpu_wait_n_o = ~cpu_pending;
  assign bus.cpu_d_o      = cpu_d_q;
  assign bus.dl_ready_o   = dl_ready_q;
  assign bus.mem_ce_o     = mem_ce_q;
  assign bus.mem_we_o     = mem_we_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_d_o      = mem_d_q;
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_cv_mem_arbiter.sv
// Directed bench for cv_mem_arbiter: latency, round-robin, download burst,
// request drop and mid-access reset, against a small byte-memory model.
module tb_cv_mem_arbiter;
  localparam int ADDR_W = 22;
  localparam int RD_LAT = 2;

  logic clk_i;
  logic reset_n_i;
  int   n_checks;
  int   n_pass;
  int   strobe_cnt;

  cv_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  cv_mem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .bus      (bus)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // memory model: read data is visible only in the cycle RD_LAT after the strobe
  logic [7:0] mem [logic [ADDR_W-1:0]];
  logic [7:0] rd_pipe [0:RD_LAT];

  initial for (int i = 0; i <= RD_LAT; i++) rd_pipe[i] = 8'hEE;

  always @(negedge clk_i) begin
    for (int i = RD_LAT; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
    rd_pipe[0] = 8'hEE;
    if (bus.mem_ce_o) begin
      strobe_cnt++;
      if (bus.mem_we_o) mem[bus.mem_addr_o] = bus.mem_d_o;
      else if (mem.exists(bus.mem_addr_o)) rd_pipe[0] = mem[bus.mem_addr_o];
    end
  end

  assign bus.mem_q_i = rd_pipe[RD_LAT];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (bus.mem_ce_o !== 1'b0) $display("FAIL rst_ce: got %b expected 0", bus.mem_ce_o); else n_pass++;
    n_checks++; if (bus.mem_we_o !== 1'b0) $display("FAIL rst_we: got %b expected 0", bus.mem_we_o); else n_pass++;
    n_checks++; if (bus.mem_addr_o !== 22'h0) $display("FAIL rst_addr: got %h expected 0", bus.mem_addr_o); else n_pass++;
    n_checks++; if (bus.mem_d_o !== 8'h00) $display("FAIL rst_d: got %h expected 00", bus.mem_d_o); else n_pass++;
    n_checks++; if (bus.cpu_d_o !== 8'hFF) $display("FAIL rst_cpu_d: got %h expected ff", bus.cpu_d_o); else n_pass++;
    n_checks++; if (bus.dl_ready_o !== 1'b0) $display("FAIL rst_ready: got %b expected 0", bus.dl_ready_o); else n_pass++;
    n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL rst_busy: got %b expected 0", bus.busy_o); else n_pass++;
    n_checks++; if (bus.cpu_wait_n_o !== 1'b1) $display("FAIL rst_wait: got %b expected 1", bus.cpu_wait_n_o); else n_pass++;
    n_checks++; if (bus.state_dbg !== 2'd0) $display("FAIL rst_state: got %0d expected 0", bus.state_dbg); else n_pass++;
    @(posedge clk_i);
    #2 reset_n_i = 1'b1;
    next_cycle();
  endtask

  task automatic test_cpu_read();
    int s0;
    mem[22'h000123] = 8'h5A;
    s0 = strobe_cnt;
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 22'h000123;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      n_checks++; if (bus.cpu_wait_n_o !== (c >= 4)) $display("FAIL rd_wait c%0d: got %b expected %b", c, bus.cpu_wait_n_o, (c >= 4)); else n_pass++;
      n_checks++; if (bus.mem_ce_o !== (c == 1)) $display("FAIL rd_ce c%0d: got %b expected %b", c, bus.mem_ce_o, (c == 1)); else n_pass++;
      if (c == 1) begin
        n_checks++; if (bus.mem_we_o !== 1'b0) $display("FAIL rd_we: got %b expected 0", bus.mem_we_o); else n_pass++;
        n_checks++; if (bus.mem_addr_o !== 22'h000123) $display("FAIL rd_addr: got %h expected 000123", bus.mem_addr_o); else n_pass++;
      end
      if (c == 4) begin
        n_checks++; if (bus.cpu_d_o !== 8'h5A) $display("FAIL rd_data: got %h expected 5a", bus.cpu_d_o); else n_pass++;
      end
      next_cycle();
    end
    bus.cpu_req_i = 1'b0;
    next_cycle();
    n_checks++; if (strobe_cnt - s0 != 1) $display("FAIL rd_strobes: got %0d expected 1", strobe_cnt - s0); else n_pass++;
  endtask

  task automatic test_cpu_write();
    logic [7:0] got;
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b1; bus.cpu_addr_i = 22'h3FFFFF; bus.cpu_d_i = 8'hC3;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      n_checks++; if (bus.mem_ce_o !== (c == 1)) $display("FAIL wr_ce c%0d: got %b expected %b", c, bus.mem_ce_o, (c == 1)); else n_pass++;
      n_checks++; if (bus.cpu_wait_n_o !== (c >= 2)) $display("FAIL wr_wait c%0d: got %b expected %b", c, bus.cpu_wait_n_o, (c >= 2)); else n_pass++;
      if (c == 1) begin
        n_checks++; if (bus.mem_we_o !== 1'b1) $display("FAIL wr_we: got %b expected 1", bus.mem_we_o); else n_pass++;
        n_checks++; if (bus.mem_addr_o !== 22'h3FFFFF) $display("FAIL wr_addr: got %h expected 3fffff", bus.mem_addr_o); else n_pass++;
        n_checks++; if (bus.mem_d_o !== 8'hC3) $display("FAIL wr_d: got %h expected c3", bus.mem_d_o); else n_pass++;
      end
      next_cycle();
    end
    bus.cpu_req_i = 1'b0;
    next_cycle();
    got = mem.exists(22'h3FFFFF) ? mem[22'h3FFFFF] : 8'hxx;
    n_checks++; if (got !== 8'hC3) $display("FAIL wr_mem: got %h expected c3", got); else n_pass++;
  endtask

  task automatic test_dl_burst();
    int beat;
    int cyc;
    int rdy_cyc [16];
    logic [7:0] got;
    beat = 0; cyc = 0;
    bus.dl_valid_i = 1'b1; bus.dl_addr_i = 22'h0; bus.dl_d_i = 8'h30;
    while (beat < 16 && cyc < 100) begin
      @(negedge clk_i);
      if (bus.dl_ready_o) begin
        rdy_cyc[beat] = cyc;
        beat++;
      end
      next_cycle();
      cyc++;
      if (beat < 16) begin
        bus.dl_addr_i = 22'(beat);
        bus.dl_d_i    = 8'h30 + 8'(beat);
      end else begin
        bus.dl_valid_i = 1'b0;
      end
    end
    bus.dl_valid_i = 1'b0;
    n_checks++; if (beat != 16) $display("FAIL dl_beats: got %0d expected 16", beat); else n_pass++;
    n_checks++; if (rdy_cyc[0] != 1) $display("FAIL dl_first: got %0d expected 1", rdy_cyc[0]); else n_pass++;
    for (int i = 1; i < 16; i++) begin
      n_checks++; if (rdy_cyc[i] - rdy_cyc[i-1] != 2) $display("FAIL dl_gap%0d: got %0d expected 2", i, rdy_cyc[i] - rdy_cyc[i-1]); else n_pass++;
    end
    for (int i = 0; i < 16; i++) begin
      got = mem.exists(22'(i)) ? mem[22'(i)] : 8'hxx;
      n_checks++; if (got !== 8'h30 + 8'(i)) $display("FAIL dl_mem%0d: got %h expected %h", i, got, 8'h30 + 8'(i)); else n_pass++;
    end
  endtask

  task automatic test_collision();
    int cpu_c, dl_c;
    logic [ADDR_W-1:0] ca;
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b1; bus.cpu_addr_i = 22'h000101; bus.cpu_d_i = 8'h44;
        repeat (3) next_cycle();
        bus.cpu_req_i = 1'b0;
        next_cycle();
      end
      ca = (r == 0) ? 22'h000100 : 22'h000102;
      bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b1; bus.cpu_addr_i = ca; bus.cpu_d_i = 8'h11 + 8'(r);
      bus.dl_valid_i = 1'b1; bus.dl_addr_i = 22'h000200 + 22'(r); bus.dl_d_i = 8'h22 + 8'(r);
      cpu_c = -1; dl_c = -1;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk_i);
        if (bus.mem_ce_o && bus.mem_addr_o == ca && cpu_c < 0) cpu_c = c;
        if (bus.dl_ready_o && dl_c < 0) dl_c = c;
        next_cycle();
        if (dl_c >= 0) bus.dl_valid_i = 1'b0;
      end
      bus.cpu_req_i = 1'b0;
      bus.dl_valid_i = 1'b0;
      next_cycle();
      n_checks++; if (cpu_c != ((r == 0) ? 1 : 3)) $display("FAIL coll%0d_cpu: got %0d expected %0d", r, cpu_c, (r == 0) ? 1 : 3); else n_pass++;
      n_checks++; if (dl_c != ((r == 0) ? 3 : 1)) $display("FAIL coll%0d_dl: got %0d expected %0d", r, dl_c, (r == 0) ? 3 : 1); else n_pass++;
    end
  endtask

  task automatic test_req_drop();
    int s0;
    mem[22'h000055] = 8'hA7;
    mem[22'h000056] = 8'h3C;
    s0 = strobe_cnt;
    for (int c = 0; c < 9; c++) begin
      if (c == 0) begin bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 22'h000055; end
      if (c == 2) bus.cpu_req_i = 1'b0;
      if (c == 4) begin bus.cpu_req_i = 1'b1; bus.cpu_addr_i = 22'h000056; end
      @(negedge clk_i);
      if (c == 1) begin
        n_checks++; if (bus.mem_ce_o !== 1'b1) $display("FAIL drop_ce1: got %b expected 1", bus.mem_ce_o); else n_pass++;
      end
      if (c == 2) begin
        n_checks++; if (bus.cpu_wait_n_o !== 1'b1) $display("FAIL drop_wait2: got %b expected 1", bus.cpu_wait_n_o); else n_pass++;
      end
      if (c == 4) begin
        n_checks++; if (bus.cpu_wait_n_o !== 1'b0) $display("FAIL drop_wait4: got %b expected 0", bus.cpu_wait_n_o); else n_pass++;
        n_checks++; if (bus.cpu_d_o !== 8'hA7) $display("FAIL drop_data1: got %h expected a7", bus.cpu_d_o); else n_pass++;
      end
      if (c == 5) begin
        n_checks++; if (bus.mem_ce_o !== 1'b1 || bus.mem_addr_o !== 22'h000056) $display("FAIL drop_ce5: got %b/%h expected 1/000056", bus.mem_ce_o, bus.mem_addr_o); else n_pass++;
      end
      if (c == 8) begin
        n_checks++; if (bus.cpu_d_o !== 8'h3C) $display("FAIL drop_data2: got %h expected 3c", bus.cpu_d_o); else n_pass++;
        n_checks++; if (bus.cpu_wait_n_o !== 1'b1) $display("FAIL drop_wait8: got %b expected 1", bus.cpu_wait_n_o); else n_pass++;
      end
      next_cycle();
    end
    bus.cpu_req_i = 1'b0;
    next_cycle();
    n_checks++; if (strobe_cnt - s0 != 2) $display("FAIL drop_strobes: got %0d expected 2", strobe_cnt - s0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dl_c;
    logic [ADDR_W-1:0] a;
    mem[22'h000077] = 8'h61;
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 22'h000077;
    next_cycle();
    next_cycle();
    bus.dl_valid_i = 1'b1; bus.dl_addr_i = 22'h000300; bus.dl_d_i = 8'h99;
    n_checks++; if (bus.state_dbg !== 2'd3) $display("FAIL rmid_pre_state: got %0d expected 3", bus.state_dbg); else n_pass++;
    #2 reset_n_i = 1'b0;
    #1;
    n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL rmid_busy: got %b expected 0", bus.busy_o); else n_pass++;
    n_checks++; if (bus.mem_ce_o !== 1'b0) $display("FAIL rmid_ce: got %b expected 0", bus.mem_ce_o); else n_pass++;
    n_checks++; if (bus.mem_addr_o !== 22'h0) $display("FAIL rmid_addr: got %h expected 0", bus.mem_addr_o); else n_pass++;
    n_checks++; if (bus.cpu_d_o !== 8'hFF) $display("FAIL rmid_cpu_d: got %h expected ff", bus.cpu_d_o); else n_pass++;
    n_checks++; if (bus.cpu_wait_n_o !== 1'b0) $display("FAIL rmid_wait: got %b expected 0", bus.cpu_wait_n_o); else n_pass++;
    bus.cpu_req_i = 1'b0;
    @(posedge clk_i);
    #2 reset_n_i = 1'b1;
    dl_c = -1; a = '0;
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      @(negedge clk_i);
      if (bus.dl_ready_o && dl_c < 0) begin dl_c = c; a = bus.mem_addr_o; end
    end
    bus.dl_valid_i = 1'b0;
    next_cycle();
    n_checks++; if (dl_c != 1) $display("FAIL rmid_dl_cycle: got %0d expected 1", dl_c); else n_pass++;
    n_checks++; if (a !== 22'h000300) $display("FAIL rmid_dl_addr: got %h expected 000300", a); else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; strobe_cnt = 0;
    reset_n_i = 1'b0;
    bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = '0; bus.cpu_d_i = 8'h00;
    bus.dl_valid_i = 1'b0; bus.dl_addr_i = '0; bus.dl_d_i = 8'h00;
    #20;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_dl_burst();
    test_collision();
    test_req_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
